// File: rtl/alu_pkg.sv
// Shared field layout, widths and controller state encoding for the ALU issue path.
package alu_pkg;
    localparam int OP_W    = 3;
    localparam int OPND_W  = 6;
    localparam int INSTR_W = 15;
    localparam int OP_MSB  = 14;
    localparam int A_MSB   = 11;
    localparam int B_MSB   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ctrl_state_t;

    function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] word);
        return word[OP_MSB -: OP_W];
    endfunction
endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer; push is ignored when full, pop is ignored when empty.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r < CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != CNT_W'(0));
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == CNT_W'(0));

    // Storage, pointers (wrapping modulo DEPTH) and occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers instruction words, issues them one at a time to split/ALU, waits the ALU
// latency and hands each result plus its opcode downstream over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int RES_W   = 12
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_data,
    output logic                       in_ready,
    output logic [INSTR_W-1:0]         alu_data,
    output logic                       alu_start,
    input  logic [RES_W-1:0]           alu_result,
    output logic                       out_valid,
    output logic [RES_W-1:0]           out_result,
    output logic [OP_W-1:0]            out_op,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    ctrl_state_t        state_r;
    ctrl_state_t        state_nxt_s;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [LAT_W-1:0]   lat_nxt_s;
    logic               pop_s;
    logic               push_s;
    logic               capture_s;
    logic               empty_s;
    logic [INSTR_W-1:0] head_s;
    logic [CNT_W-1:0]   count_s;
    logic [INSTR_W-1:0] alu_data_r;
    logic               alu_start_r;
    logic               out_valid_r;
    logic [RES_W-1:0]   out_result_r;
    logic [OP_W-1:0]    out_op_r;

    // in_ready looks only at the registered occupancy, never at a same-cycle pop.
    assign in_ready = (count_s < CNT_W'(DEPTH));
    assign push_s   = in_valid && in_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .empty     (empty_s)
    );

    // Next-state, pop request, latency countdown and capture strobe.
    always_comb begin
        state_nxt_s = state_r;
        lat_nxt_s   = lat_cnt_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (ALU_LAT == 1) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    lat_nxt_s   = LAT_W'(ALU_LAT - 1);
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_r <= LAT_W'(1)) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    lat_nxt_s   = lat_cnt_r - LAT_W'(1);
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus registered datapath/handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            lat_cnt_r    <= LAT_W'(0);
            alu_data_r   <= {INSTR_W{1'b0}};
            alu_start_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {RES_W{1'b0}};
            out_op_r     <= {OP_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            lat_cnt_r   <= lat_nxt_s;
            alu_start_r <= (state_nxt_s == ISSUE);
            out_valid_r <= (state_nxt_s == HOLD);
            if (pop_s) begin
                alu_data_r <= head_s;
            end
            if (capture_s) begin
                out_result_r <= alu_result;
                out_op_r     <= get_op(alu_data_r);
            end
        end
    end

    assign alu_data   = alu_data_r;
    assign alu_start  = alu_start_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_op     = out_op_r;
    assign count      = count_s;
    assign busy       = (state_r != IDLE) || !empty_s;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table-driven single-word vectors, directed multi-cycle
// sequences and a randomized stream scored against an in-order result queue.
module tb_alu_issue_ctrl;
    logic        clock;
    logic        reset_n;

    logic        in_valid, in_ready, alu_start, out_valid, out_ready, busy;
    logic [14:0] in_data, alu_data;
    logic [11:0] alu_result, out_result, noise;
    logic [2:0]  out_op;
    logic [2:0]  count;

    logic        in_valid1, in_ready1, alu_start1, out_valid1, out_ready1, busy1;
    logic [14:0] in_data1, alu_data1;
    logic [11:0] alu_result1, out_result1;
    logic [2:0]  out_op1;
    logic [2:0]  count1;

    int checks = 0;
    int failures = 0;
    int n_results = 0;
    logic [14:0] sb[$];

    // Stand-in ALU: result is a pure function of the issued word.
    function automatic logic [11:0] alu_f(input logic [14:0] w);
        logic [11:0] a, b;
        a = {6'd0, w[11:6]};
        b = {6'd0, w[5:0]};
        return a * b + {9'd0, w[14:12]};
    endfunction

    assign alu_result  = alu_f(alu_data) ^ noise;
    assign alu_result1 = alu_f(alu_data1);

    alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(3), .RES_W(12)) dut3 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .alu_data(alu_data), .alu_start(alu_start),
        .alu_result(alu_result), .out_valid(out_valid), .out_result(out_result),
        .out_op(out_op), .out_ready(out_ready), .busy(busy), .count(count)
    );

    alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(1), .RES_W(12)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .alu_data(alu_data1), .alu_start(alu_start1),
        .alu_result(alu_result1), .out_valid(out_valid1), .out_result(out_result1),
        .out_op(out_op1), .out_ready(out_ready1), .busy(busy1), .count(count1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: accepted words queue in order; each result handshake consumes one.
    initial begin
        logic [14:0] w;
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                sb.delete();
            end else begin
                if (in_valid && in_ready) sb.push_back(in_data);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_result", 32'd1, 32'd0);
                    end else begin
                        w = sb.pop_front();
                        chk("sb_op", out_op, w[14:12]);
                        chk("sb_result", out_result, alu_f(w));
                        n_results++;
                    end
                end
            end
            if (alu_start) chk("start_gap", prev_start, 1'b0);
            prev_start = alu_start;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", (n < 300), 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk(name, out_valid, 1'b1);
    endtask

    typedef struct {
        logic [14:0] word;
        logic [2:0]  op;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] res;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, starts, base;
        logic [14:0] seen;
        logic [11:0] held_res;
        logic [2:0]  held_op;
        logic        seen_valid;
        int st[$];

        tbl[0] = '{15'h1234, 3'd1, 6'd8,  6'd52, 12'h1A1};
        tbl[1] = '{15'h7FFF, 3'd7, 6'd63, 6'd63, 12'hF88};
        tbl[2] = '{15'h0000, 3'd0, 6'd0,  6'd0,  12'h000};
        tbl[3] = '{15'h4041, 3'd4, 6'd1,  6'd1,  12'h005};
        tbl[4] = '{15'h2FC0, 3'd2, 6'd63, 6'd0,  12'h002};
        tbl[5] = '{15'h30C5, 3'd3, 6'd3,  6'd5,  12'h012};

        reset_n = 1'b0; noise = 12'd0;
        in_valid = 1'b0; in_data = 15'd0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = 15'd0; out_ready1 = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst_alu_data", alu_data, 15'd0);
        chk("rst_alu_start", alu_start, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 12'd0);
        chk("rst_out_op", out_op, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst1_out_valid", out_valid1, 1'b0);
        chk("rst1_in_ready", in_ready1, 1'b1);

        // Table: one word into an idle controller, ALU_LAT=3.
        for (int i = 0; i < 6; i++) begin
            in_data = tbl[i].word; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 0; starts = 0; seen = 15'd0;
            while (!out_valid && lat < 20) begin
                if (alu_start) begin starts++; seen = alu_data; end
                step();
                lat++;
            end
            chk("tbl_latency", lat, 4);
            chk("tbl_start_count", starts, 1);
            chk("tbl_split_op", seen[14:12], tbl[i].op);
            chk("tbl_split_a", seen[11:6], tbl[i].a);
            chk("tbl_split_b", seen[5:0], tbl[i].b);
            chk("tbl_out_op", out_op, tbl[i].op);
            chk("tbl_out_result", out_result, tbl[i].res);
            step();
            chk("tbl_valid_drop", out_valid, 1'b0);
        end

        // ALU_LAT=1 instance: 15'h1234.
        in_data1 = 15'h1234; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        lat = 0; starts = 0; seen = 15'd0;
        while (!out_valid1 && lat < 20) begin
            if (alu_start1) begin starts++; seen = alu_data1; end
            step();
            lat++;
        end
        chk("lat1_latency", lat, 2);
        chk("lat1_start_count", starts, 1);
        chk("lat1_alu_data", seen, 15'h1234);
        chk("lat1_out_op", out_op1, 3'd1);
        chk("lat1_out_result", out_result1, 12'h1A1);

        // Back-to-back: three words, starts 4 cycles apart.
        for (int i = 0; i < 24; i++) begin
            if (alu_start) st.push_back(i);
            in_valid = (i < 3);
            in_data  = 15'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("b2b_starts", st.size(), 3);
        if (st.size() == 3) begin
            chk("b2b_gap0", st[1] - st[0], 4);
            chk("b2b_gap1", st[2] - st[1], 4);
        end
        drain();

        // Backpressure: five words, four buffered plus one in HOLD.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 1'b1);
            in_valid = 1'b1; in_data = 15'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_count", count, 3'd4);
        chk("bp_full", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        base = n_results;
        drain();
        chk("bp_results", n_results - base, 5);

        // Simultaneous push and pop at count=2.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 15'($urandom);
            step();
        end
        in_valid = 1'b0;
        wait_valid("pp_valid");
        chk("pp_pre_count", count, 3'd2);
        in_valid = 1'b1; in_data = 15'($urandom); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_count", count, 3'd2);
        drain();

        // Reset during WAIT with two words buffered.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 15'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("mrst_pre_count", count, 3'd2);
        reset_n = 1'b0;
        step();
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_count", count, 3'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        base = n_results; seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_valid = seen_valid | out_valid;
        end
        chk("mrst_no_output", seen_valid, 1'b0);
        chk("mrst_no_results", n_results - base, 0);

        // Result hold while alu_result moves.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 15'h5A5A;
        step();
        in_valid = 1'b0;
        wait_valid("hold_valid_rise");
        held_res = out_result;
        held_op  = out_op;
        chk("hold_initial_result", held_res, alu_f(15'h5A5A));
        for (int i = 0; i < 5; i++) begin
            noise = 12'($urandom_range(1, 4095));
            step();
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", out_result, held_res);
            chk("hold_op", out_op, held_op);
        end
        noise = 12'd0;
        drain();

        // Randomized stream with random backpressure.
        base = n_results;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 15'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_some_results", (n_results - base > 10), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
